// File: rtl/blockram_fifo_ctrl_pkg.sv
// Shared constants and types for the blockram-backed FIFO controller.
// Defaults must match the attached dual_port_blockram geometry.
package blockram_fifo_ctrl_pkg;

  localparam int unsigned SingleElementSizeInBits = 64;
  localparam int unsigned NumberSets              = 64;
  localparam int unsigned SetPtrWidthInBits       = 6;

  typedef enum logic [1:0] {
    SkidEmpty = 2'd0,
    SkidOne   = 2'd1,
    SkidTwo   = 2'd2
  } skid_state_e;

  // Entries that will sit in the skid buffer after this edge, before any new read lands.
  function automatic logic [2:0] skid_pending(logic [1:0] count, logic inflight, logic pop);
    return {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/blockram_fifo_ctrl_if.sv
// Push/pop stream and blockram command bundle for blockram_fifo_ctrl.
// The slave modport is the controller; master is the surrounding logic and RAM.
interface blockram_fifo_ctrl_if #(
  parameter int unsigned SINGLE_ELEMENT_SIZE_IN_BITS =
    blockram_fifo_ctrl_pkg::SingleElementSizeInBits,
  parameter int unsigned SET_PTR_WIDTH_IN_BITS = blockram_fifo_ctrl_pkg::SetPtrWidthInBits
);

  logic                                   push_valid_in;
  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] push_element_in;
  logic                                   push_ready_out;
  logic                                   pop_valid_out;
  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] pop_element_out;
  logic                                   pop_ready_in;
  logic                                   ram_write_en_out;
  logic [SET_PTR_WIDTH_IN_BITS-1:0]       ram_write_set_addr_out;
  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] ram_write_element_out;
  logic                                   ram_read_en_out;
  logic [SET_PTR_WIDTH_IN_BITS-1:0]       ram_read_set_addr_out;
  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] ram_read_element_in;
  logic [SET_PTR_WIDTH_IN_BITS:0]         occupancy_out;
  logic                                   full_out;
  logic                                   empty_out;

  modport slave (
    input  push_valid_in, push_element_in, pop_ready_in, ram_read_element_in,
    output push_ready_out, pop_valid_out, pop_element_out,
    output ram_write_en_out, ram_write_set_addr_out, ram_write_element_out,
    output ram_read_en_out, ram_read_set_addr_out,
    output occupancy_out, full_out, empty_out
  );

  modport master (
    output push_valid_in, push_element_in, pop_ready_in, ram_read_element_in,
    input  push_ready_out, pop_valid_out, pop_element_out,
    input  ram_write_en_out, ram_write_set_addr_out, ram_write_element_out,
    input  ram_read_en_out, ram_read_set_addr_out,
    input  occupancy_out, full_out, empty_out
  );

endinterface

// File: rtl/blockram_fifo_ctrl_skid_buffer.sv
// Two-entry registered skid buffer holding the FIFO head; absorbs blockram read latency.
module blockram_fifo_ctrl_skid_buffer
  import blockram_fifo_ctrl_pkg::*;
#(
  parameter int unsigned SINGLE_ELEMENT_SIZE_IN_BITS = SingleElementSizeInBits
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   fill_i,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] fill_data_i,
  input  logic                                   drain_i,
  output logic                                   valid_o,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] head_o,
  output logic [1:0]                             count_o
);

  skid_state_e                            state_q, state_d;
  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] head_q, head_d;
  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] tail_q, tail_d;
  logic                                   drain;

  assign drain = drain_i && (state_q != SkidEmpty);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SkidEmpty;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SkidEmpty: if (fill_i) state_d = SkidOne;
      SkidOne: begin
        if (fill_i && !drain)      state_d = SkidTwo;
        else if (!fill_i && drain) state_d = SkidEmpty;
      end
      SkidTwo:   if (drain && !fill_i) state_d = SkidOne;
      default:   state_d = SkidEmpty;
    endcase
  end

  // New data lands at the head only when the head slot is (or is becoming) free.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (drain && (state_q == SkidTwo)) head_d = tail_q;
    if (fill_i) begin
      if ((state_q == SkidEmpty) || ((state_q == SkidOne) && drain)) head_d = fill_data_i;
      else                                                            tail_d = fill_data_i;
    end
  end

  always_comb begin
    valid_o = (state_q != SkidEmpty);
    head_o  = head_q;
    count_o = state_q;
  end

endmodule

// File: rtl/blockram_fifo_ctrl.sv
// FIFO controller using dual_port_blockram as storage, with a first-word-fall-through pop side.
// Optional BLOCKRAM_FIFO_BYPASS_EN routes pushes straight to the skid buffer when RAM is idle.
module blockram_fifo_ctrl
  import blockram_fifo_ctrl_pkg::*;
#(
  parameter int unsigned SINGLE_ELEMENT_SIZE_IN_BITS = SingleElementSizeInBits,
  parameter int unsigned NUMBER_SETS                 = NumberSets,
  parameter int unsigned SET_PTR_WIDTH_IN_BITS       = SetPtrWidthInBits
) (
  input logic               clk_in,
  input logic               reset_in,
  blockram_fifo_ctrl_if.slave bus
);

  localparam int unsigned PtrW = SET_PTR_WIDTH_IN_BITS + 1;
  localparam logic [PtrW-1:0] Cap = PtrW'(NUMBER_SETS);

  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [PtrW-1:0] occ_q, occ_d;
  logic            push_ready_q, push_ready_d;
  logic            inflight_q, inflight_d;

  logic [PtrW-1:0]                        ram_count;
  logic                                   ram_empty;
  logic                                   push_fire, pop_fire, read_en, bypass;
  logic [2:0]                             pending;
  logic                                   skid_valid;
  logic [1:0]                             skid_count;
  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] skid_head;
  logic                                   skid_fill;
  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] skid_fill_data;

  // Gated by reset so nothing is accepted while reset_in is held low.
  assign push_fire = bus.push_valid_in && push_ready_q && reset_in;
  assign pop_fire  = skid_valid && bus.pop_ready_in;
  assign ram_count = wptr_q - rptr_q;
  assign ram_empty = (ram_count == '0);
  assign pending   = skid_pending(skid_count, inflight_q, pop_fire);
  assign read_en   = !ram_empty && (pending < 3'd2);

`ifdef BLOCKRAM_FIFO_BYPASS_EN
  assign bypass = push_fire && ram_empty && !inflight_q && (pending < 3'd2);
`else
  assign bypass = 1'b0;
`endif

  assign skid_fill      = inflight_q || bypass;
  assign skid_fill_data = inflight_q ? bus.ram_read_element_in : bus.push_element_in;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      occ_q        <= '0;
      push_ready_q <= 1'b1;
      inflight_q   <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      occ_q        <= occ_d;
      push_ready_q <= push_ready_d;
      inflight_q   <= inflight_d;
    end
  end

  // Bypassed elements advance both pointers so the RAM count stays at zero.
  always_comb begin
    wptr_d       = wptr_q + PtrW'(push_fire);
    rptr_d       = rptr_q + PtrW'(read_en || bypass);
    occ_d        = occ_q + PtrW'(push_fire) - PtrW'(pop_fire);
    push_ready_d = (occ_d < Cap);
    inflight_d   = read_en;
  end

  always_comb begin
    bus.push_ready_out         = push_ready_q;
    bus.pop_valid_out          = skid_valid;
    bus.pop_element_out        = skid_head;
    bus.ram_write_en_out       = push_fire && !bypass;
    bus.ram_write_set_addr_out = '0;
    bus.ram_write_element_out  = '0;
    if (push_fire && !bypass) begin
      bus.ram_write_set_addr_out = wptr_q[SET_PTR_WIDTH_IN_BITS-1:0];
      bus.ram_write_element_out  = bus.push_element_in;
    end
    bus.ram_read_en_out       = read_en;
    bus.ram_read_set_addr_out = read_en ? rptr_q[SET_PTR_WIDTH_IN_BITS-1:0] : '0;
    bus.occupancy_out         = occ_q;
    bus.full_out              = (occ_q == Cap);
    bus.empty_out             = (occ_q == '0);
  end

  blockram_fifo_ctrl_skid_buffer #(
    .SINGLE_ELEMENT_SIZE_IN_BITS(SINGLE_ELEMENT_SIZE_IN_BITS)
  ) u_skid (
    .clk_i       (clk_in),
    .rst_ni      (reset_in),
    .fill_i      (skid_fill),
    .fill_data_i (skid_fill_data),
    .drain_i     (bus.pop_ready_in),
    .valid_o     (skid_valid),
    .head_o      (skid_head),
    .count_o     (skid_count)
  );

endmodule

// File: tb/tb_blockram_fifo_ctrl.sv
// Self-checking bench for blockram_fifo_ctrl with a behavioural blockram and a data scoreboard.
module tb_blockram_fifo_ctrl;

  localparam int unsigned D = 64;
`ifdef BLOCKRAM_FIFO_BYPASS_EN
  localparam int Lat = 1;
  localparam logic LatWrEn = 1'b0;
`else
  localparam int Lat = 3;
  localparam logic LatWrEn = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  blockram_fifo_ctrl_if bif ();

  blockram_fifo_ctrl dut (
    .clk_in   (clk),
    .reset_in (rst_n),
    .bus      (bif)
  );

  // Registered-read blockram model.
  logic [63:0] mem [D];
  logic [63:0] ram_rd = '0;
  always @(posedge clk) begin
    if (bif.ram_write_en_out) mem[bif.ram_write_set_addr_out] <= bif.ram_write_element_out;
    if (bif.ram_read_en_out)  ram_rd <= mem[bif.ram_read_set_addr_out];
  end
  assign bif.ram_read_element_in = ram_rd;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] sb[$];
  logic [5:0]  raq[$];
  int occ_m = 0;
  int wcnt = 0;
  int pops = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic monitor();
    logic push_f, pop_f;
    if (!rst_n) return;
    push_f = bif.push_valid_in && bif.push_ready_out;
    pop_f  = bif.pop_valid_out && bif.pop_ready_in;
    chk("occupancy", 64'(bif.occupancy_out), 64'(occ_m));
    chk("empty", 64'(bif.empty_out), 64'(occ_m == 0));
    chk("full", 64'(bif.full_out), 64'(occ_m == D));
    chk("push_ready", 64'(bif.push_ready_out), 64'(occ_m < D));
`ifndef BLOCKRAM_FIFO_BYPASS_EN
    chk("wr_en", 64'(bif.ram_write_en_out), 64'(push_f));
`endif
    chk("wr_without_push", 64'(bif.ram_write_en_out && !push_f), 64'(0));
    if (bif.ram_read_en_out) begin
      chk("rd_has_data", 64'(raq.size() != 0), 64'(1));
      if (raq.size() != 0) chk("rd_addr", 64'(bif.ram_read_set_addr_out), 64'(raq.pop_front()));
      if (bif.ram_write_en_out)
        chk("collision", 64'(bif.ram_write_set_addr_out == bif.ram_read_set_addr_out), 64'(0));
    end
    if (bif.ram_write_en_out) begin
      chk("wr_addr", 64'(bif.ram_write_set_addr_out), 64'(wcnt % D));
      chk("wr_data", bif.ram_write_element_out, bif.push_element_in);
      raq.push_back(bif.ram_write_set_addr_out);
    end
    if (push_f) begin
      sb.push_back(bif.push_element_in);
      wcnt++;
      occ_m++;
    end
    if (pop_f) begin
      chk("pop_has_data", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) chk("pop_data", bif.pop_element_out, sb.pop_front());
      occ_m--;
      pops++;
    end
  endtask

  task automatic cycle(input logic pv, input logic [63:0] pd, input logic pr);
    @(negedge clk);
    bif.push_valid_in   = pv;
    bif.push_element_in = pd;
    bif.pop_ready_in    = pr;
    #1;
    monitor();
  endtask

  task automatic check_reset_vals();
    chk("rst_push_ready", 64'(bif.push_ready_out), 64'(1));
    chk("rst_pop_valid", 64'(bif.pop_valid_out), 64'(0));
    chk("rst_pop_elem", bif.pop_element_out, 64'(0));
    chk("rst_wr_en", 64'(bif.ram_write_en_out), 64'(0));
    chk("rst_wr_addr", 64'(bif.ram_write_set_addr_out), 64'(0));
    chk("rst_wr_data", bif.ram_write_element_out, 64'(0));
    chk("rst_rd_en", 64'(bif.ram_read_en_out), 64'(0));
    chk("rst_rd_addr", 64'(bif.ram_read_set_addr_out), 64'(0));
    chk("rst_occ", 64'(bif.occupancy_out), 64'(0));
    chk("rst_empty", 64'(bif.empty_out), 64'(1));
    chk("rst_full", 64'(bif.full_out), 64'(0));
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      cycle(1'b0, 64'd0, 1'b1);
      n++;
    end
    chk("drain_done", 64'(sb.size()), 64'(0));
    repeat (2) cycle(1'b0, 64'd0, 1'b0);
  endtask

  initial begin
    int n;
    bif.push_valid_in   = 1'b1;
    bif.push_element_in = 64'hDEAD_BEEF_0123_4567;
    bif.pop_ready_in    = 1'b0;
    rst_n               = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check_reset_vals();
    bif.push_valid_in = 1'b0;
    rst_n = 1'b1;

    // Single element latency.
    cycle(1'b1, 64'h0000_0000_FFFF_FFFF, 1'b0);
    chk("lat_wr_en", 64'(bif.ram_write_en_out), 64'(LatWrEn));
    chk("lat_wr_addr", 64'(bif.ram_write_set_addr_out), 64'(0));
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b0, 64'd0, 1'b0);
      chk($sformatf("lat_valid_%0d", i), 64'(bif.pop_valid_out), 64'(i >= Lat));
    end
    chk("lat_data", bif.pop_element_out, 64'h0000_0000_FFFF_FFFF);
    cycle(1'b0, 64'd0, 1'b1);
    cycle(1'b0, 64'd0, 1'b0);
    chk("lat_empty_after", 64'(bif.empty_out), 64'(1));

    // Fill to capacity, then attempt an overflow push.
    for (int i = 0; i < 64; i++) cycle(1'b1, 64'(i), 1'b0);
    repeat (3) cycle(1'b0, 64'd0, 1'b0);
    chk("fill_full", 64'(bif.full_out), 64'(1));
    chk("fill_ready", 64'(bif.push_ready_out), 64'(0));
    chk("fill_occ", 64'(bif.occupancy_out), 64'(64));
    cycle(1'b1, 64'd64, 1'b0);
    chk("ovf_wr", 64'(bif.ram_write_en_out), 64'(0));
    chk("ovf_ready", 64'(bif.push_ready_out), 64'(0));
    chk("ovf_wcnt", 64'(wcnt), 64'(65));

    // Streaming from full: one pop every cycle.
    pops = 0;
    for (int i = 0; i < 200; i++) begin
      cycle(1'b1, 64'(1000 + i), 1'b1);
      chk("tput_valid", 64'(bif.pop_valid_out), 64'(1));
    end
    chk("tput_pops", 64'(pops), 64'(200));
    drain();

    // Random traffic.
    for (int i = 0; i < 2000; i++)
      cycle(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    drain();

    // Reset in the middle of a non-empty FIFO.
    for (int i = 0; i < 10; i++) cycle(1'b1, 64'(5000 + i), 1'b0);
    repeat (4) cycle(1'b0, 64'd0, 1'b0);
    chk("pre_rst_occ", 64'(bif.occupancy_out), 64'(10));
    @(negedge clk);
    bif.push_valid_in = 1'b1;
    bif.pop_ready_in  = 1'b1;
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    sb.delete();
    raq.delete();
    occ_m = 0;
    wcnt  = 0;
    repeat (2) @(negedge clk);
    bif.push_valid_in = 1'b0;
    bif.pop_ready_in  = 1'b0;
    rst_n = 1'b1;
    cycle(1'b1, 64'hFFFF_FFFF_0000_0000, 1'b0);
    n = 0;
    while (!bif.pop_valid_out && n < 8) begin
      cycle(1'b0, 64'd0, 1'b0);
      n++;
    end
    chk("post_rst_valid", 64'(bif.pop_valid_out), 64'(1));
    chk("post_rst_first", bif.pop_element_out, 64'hFFFF_FFFF_0000_0000);
    cycle(1'b0, 64'd0, 1'b1);
    cycle(1'b0, 64'd0, 1'b0);
    chk("post_rst_empty", 64'(bif.empty_out), 64'(1));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/blockram_fifo_ctrl.md
Name: blockram_fifo_ctrl

Overview:
FIFO controller that sits directly upstream of dual_port_blockram and uses it as FIFO storage.
- Converts a valid/ready push stream and a valid/ready pop stream into blockram write and read port commands.
- Hides the blockram's 1-cycle registered read latency behind a 2-entry output skid buffer, so the pop side is first-word-fall-through.
- Used as the deep element queue in front of cache and line-buffer consumers.

Parameters:
SINGLE_ELEMENT_SIZE_IN_BITS, 64, element width; must match the attached blockram.
NUMBER_SETS, 64, blockram depth and total FIFO capacity in elements.
SET_PTR_WIDTH_IN_BITS, 6, log2(NUMBER_SETS); NUMBER_SETS must be a power of two.

Ports:
clk_in  input  1  clock; all state updates on rising edge.
reset_in  input  1  reset, asynchronous, active-low; state cleared while low.
push_valid_in  input  1  push request.
push_element_in  input  SINGLE_ELEMENT_SIZE_IN_BITS  push data.
push_ready_out  output  1  high when a push can be accepted this cycle.
pop_valid_out  output  1  head element valid.
pop_element_out  output  SINGLE_ELEMENT_SIZE_IN_BITS  head element.
pop_ready_in  input  1  consumer accepts the head element.
ram_write_en_out  output  1  to blockram write_en_in.
ram_write_set_addr_out  output  SET_PTR_WIDTH_IN_BITS  to blockram write_set_addr_in.
ram_write_element_out  output  SINGLE_ELEMENT_SIZE_IN_BITS  to blockram write_element_in.
ram_read_en_out  output  1  to blockram read_en_in.
ram_read_set_addr_out  output  SET_PTR_WIDTH_IN_BITS  to blockram read_set_addr_in.
ram_read_element_in  input  SINGLE_ELEMENT_SIZE_IN_BITS  from blockram read_element_out; valid 1 cycle after a read.
occupancy_out  output  SET_PTR_WIDTH_IN_BITS+1  accepted but not yet popped elements, 0..NUMBER_SETS.
full_out  output  1  occupancy_out == NUMBER_SETS.
empty_out  output  1  occupancy_out == 0.

Behaviour:
- Reset (reset_in low, asynchronous):
  - Write and read pointers (SET_PTR_WIDTH_IN_BITS+1 bits, MSB is the wrap bit), occupancy, in-flight flag and skid count are 0.
  - push_ready_out=1, pop_valid_out=0, pop_element_out=0, all ram_* outputs 0, empty_out=1, full_out=0.
  - Reset mid-operation discards all contents. RAM contents are not cleared and are never read before being rewritten.
- Push:
  - Accepted when push_valid_in && push_ready_out.
  - push_ready_out = registered (occupancy < NUMBER_SETS); pop in the same cycle never frees a slot combinationally.
  - An accepted push drives the ram_write_* outputs combinationally in that cycle (write_en=1, addr=wptr[low bits], element=push_element_in), then wptr increments and wraps modulo 2*NUMBER_SETS.
- RAM count = wptr - rptr (modulo, with the wrap bit); it is never NUMBER_SETS while writing.
  - A read never targets the write address in the same cycle, so there is no same-address collision by construction.
- Read issue:
  - ram_read_en_out=1 when RAM count > 0 && (skid_count + inflight) < 2, where skid_count is registered.
  - ram_read_set_addr_out = rptr[low bits]; rptr increments.
  - inflight is set for one cycle; on the next edge ram_read_element_in is written into the skid buffer.
- Skid buffer: states EMPTY(0) -> ONE(1) -> TWO(2).
  - Fill (inflight arrival) and drain (pop_valid_out && pop_ready_in) in the same cycle keep the count.
  - The head entry drives pop_element_out from a register. When the head pops with 2 entries, the second entry shifts to head.
- Occupancy:
  - +1 on push, -1 on pop, unchanged on both.
  - Push-to-pop_valid_out latency is 3 cycles: write at cycle 0, read at 1, capture at 2, visible at 3.
- Sustained throughput is one push and one pop per cycle once the pipeline is primed.
- Pop with pop_ready_in high while pop_valid_out is low is ignored.

Optional Feature:
BLOCKRAM_FIFO_BYPASS_EN
- Defined: when RAM count == 0, no read is in flight and skid_count < 2 (counting a same-cycle pop), an accepted push goes directly into the skid buffer.
  - ram_write_en_out stays 0 and wptr/rptr both advance, keeping RAM count at 0.
  - Push-to-pop latency becomes 1 cycle. Order is preserved because bypass only occurs with RAM and the in-flight slot empty.
- Undefined: every element passes through the RAM; latency is 3 cycles.

Decomposition:
- parameters.h: default element width, depth and pointer-width constants, shared with dual_port_blockram.
- Sub-module fifo_skid_buffer: 2-entry registered buffer with fill/drain/count, parameterised by SINGLE_ELEMENT_SIZE_IN_BITS.
- Pointer, occupancy and read-issue logic stay in blockram_fifo_ctrl.

Test Plan:
- Reset held low 5 cycles with push_valid_in=1 -> push_ready_out=1, pop_valid_out=0, all ram_* 0, occupancy_out=0.
- Push 0x00000000FFFFFFFF once, pop_ready_in=0 -> ram write to addr 0; pop_valid_out=1 exactly 3 cycles later (1 with BYPASS_EN), data matches.
- Push 64 sequential values 0..63, no pops -> full_out=1, push_ready_out=0; a 65th push is not accepted and no write is issued.
- At full, pop_ready_in=1 and push_valid_in=1 for 200 cycles -> output sequence 0,1,2,... in order, one pop per cycle after priming, ram addresses wrap 63->0, no address collision.
- Random push_valid_in/pop_ready_in at 50% density, 2000 cycles -> popped stream equals pushed stream, occupancy_out tracks a scoreboard count, never exceeds 64.
- Reset asserted mid-stream with occupancy 10 -> all outputs return to reset values immediately; the next push 0xFFFFFFFF00000000 is the first element popped.
